// File: rtl/ds_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ds_sample_sequencer_if
// Brief   : Sample stream, control and status bundle for ds_sample_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface ds_sample_sequencer_if #(
  parameter int IN_BITS          = 16,
  parameter int SHIFT_COUNT_BITS = 4,
  parameter int FIFO_AW          = 2,
  parameter int DIV_BITS         = 8
);
  logic [IN_BITS-1:0]          in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [DIV_BITS-1:0]         rate_div;
  logic [SHIFT_COUNT_BITS-1:0] volume_rshift;
  logic                        mute;
  logic                        ds_consume;
  logic [IN_BITS-1:0]          u;
  logic [SHIFT_COUNT_BITS-1:0] u_rshift;
  logic [FIFO_AW:0]            fifo_level;
  logic                        running;
  logic                        underrun;
  logic                        underrun_clear;

  modport master (
    output in_data, in_valid, rate_div, volume_rshift, mute, ds_consume, underrun_clear,
    input  in_ready, u, u_rshift, fifo_level, running, underrun
  );

  modport slave (
    input  in_data, in_valid, rate_div, volume_rshift, mute, ds_consume, underrun_clear,
    output in_ready, u, u_rshift, fifo_level, running, underrun
  );
endinterface
`default_nettype wire

// File: rtl/ds_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ds_sample_sequencer
// Brief   : FIFO-buffered sample feeder for a delta-sigma modulator with
//           repetition upsampling, volume latch, mute and underrun handling.
// Revision: 1.0 - initial release
// ============================================================================
module ds_sample_sequencer #(
  parameter int IN_BITS          = 16,
  parameter int SHIFT_COUNT_BITS = 4,
  parameter int FIFO_AW          = 2,
  parameter int DIV_BITS         = 8,
  parameter int PRIME_LEVEL      = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  ds_sample_sequencer_if.slave bus
);
  localparam int                 c_DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   c_DEPTH_LVL = (FIFO_AW+1)'(c_DEPTH);
  localparam logic [FIFO_AW:0]   c_PRIME_LVL = (FIFO_AW+1)'(PRIME_LEVEL);
  localparam logic [IN_BITS-1:0] c_MID       = {1'b1, {(IN_BITS-1){1'b0}}};

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_UNDERRUN = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_next_state;
  logic [IN_BITS-1:0]          r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]          r_wr_ptr;
  logic [FIFO_AW-1:0]          r_rd_ptr;
  logic [FIFO_AW:0]            r_level;
  logic [IN_BITS-1:0]          r_u;
  logic [SHIFT_COUNT_BITS-1:0] r_u_rshift;
  logic [DIV_BITS-1:0]         r_hold_cnt;
  logic                        r_underrun;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_boundary;
  logic                        w_underrun_set;
  logic                        w_running;

  assign w_push     = bus.in_valid && (r_level != c_DEPTH_LVL);
  // >= so a rate_div decrease mid-sample ends the sample on the next consume
  assign w_boundary = (r_hold_cnt >= bus.rate_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level >= c_PRIME_LVL) begin
          w_pop        = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.ds_consume && w_boundary) begin
          if (r_level != '0) begin
            w_pop = 1'b1;
          end else begin
            w_next_state   = S_UNDERRUN;
            w_underrun_set = 1'b1;
          end
        end
      end
      S_UNDERRUN: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_running = (r_state == S_RUN);
  end

  // Storage carries no reset; occupancy is tracked by pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_u        <= c_MID;
      r_u_rshift <= '0;
      r_hold_cnt <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_pop) begin
        r_u        <= r_mem[r_rd_ptr];
        r_u_rshift <= bus.volume_rshift;
        r_hold_cnt <= '0;
      end else if (w_running && bus.ds_consume && !w_boundary) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (bus.underrun_clear) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = (r_level != c_DEPTH_LVL);
  assign bus.u          = bus.mute ? c_MID : r_u;
  assign bus.u_rshift   = r_u_rshift;
  assign bus.fifo_level = r_level;
  assign bus.running    = w_running;
  assign bus.underrun   = r_underrun;
endmodule
`default_nettype wire

// File: tb/tb_ds_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ds_sample_sequencer
// Brief   : Directed and randomized bench for ds_sample_sequencer against a
//           queue-based behavioural model. Revision: 1.0 - initial release
// ============================================================================
module tb_ds_sample_sequencer;
  localparam int IN_BITS = 16;
  localparam int SHB     = 4;
  localparam int AW      = 2;
  localparam int DB      = 8;
  localparam int DEPTH   = 4;
  localparam int PRIME   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ds_sample_sequencer_if #(.IN_BITS(IN_BITS), .SHIFT_COUNT_BITS(SHB), .FIFO_AW(AW), .DIV_BITS(DB)) ifc ();

  ds_sample_sequencer #(
    .IN_BITS(IN_BITS), .SHIFT_COUNT_BITS(SHB), .FIFO_AW(AW), .DIV_BITS(DB), .PRIME_LEVEL(PRIME)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of pending samples, playback mode (0 waiting to prime, 1 playing, 2 starved),
  // the current sample and how many times it has been repeated so far.
  logic [15:0] m_q[$];
  int          m_mode;
  logic [15:0] m_u;
  logic [3:0]  m_sh;
  int          m_reps;
  bit          m_und;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_mode = 0;
      m_u    = 16'h8000;
      m_sh   = 4'd0;
      m_reps = 0;
      m_und  = 1'b0;
    end else begin
      int lvl;
      bit take;
      bit starve;
      lvl    = m_q.size();
      take   = 1'b0;
      starve = 1'b0;
      if (m_mode == 0) begin
        if (lvl >= PRIME) begin take = 1'b1; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (ifc.ds_consume) begin
          if (m_reps < int'(ifc.rate_div)) m_reps++;
          else if (lvl > 0) take = 1'b1;
          else begin m_mode = 2; starve = 1'b1; end
        end
      end else if (lvl > 0) begin
        take = 1'b1;
        m_mode = 1;
      end
      if (take) begin
        m_u    = m_q.pop_front();
        m_sh   = ifc.volume_rshift;
        m_reps = 0;
      end
      if (starve) m_und = 1'b1;
      else if (ifc.underrun_clear) m_und = 1'b0;
      if (ifc.in_valid && lvl < DEPTH) m_q.push_back(ifc.in_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("u",          32'(ifc.u),          32'(ifc.mute ? 16'h8000 : m_u));
    chk("u_rshift",   32'(ifc.u_rshift),   32'(m_sh));
    chk("fifo_level", 32'(ifc.fifo_level), 32'(m_q.size()));
    chk("in_ready",   32'(ifc.in_ready),   32'(m_q.size() != DEPTH));
    chk("running",    32'(ifc.running),    32'(m_mode == 1));
    chk("underrun",   32'(ifc.underrun),   32'(m_und));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic push(input logic [15:0] d);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    step();
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    ifc.in_data        = '0;
    ifc.in_valid       = 1'b0;
    ifc.rate_div       = 8'd2;
    ifc.volume_rshift  = 4'd3;
    ifc.mute           = 1'b0;
    ifc.ds_consume     = 1'b0;
    ifc.underrun_clear = 1'b0;
    #1 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_u", 32'(ifc.u), 32'h8000);
    chk("rst_level", 32'(ifc.fifo_level), 32'd0);
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_running", 32'(ifc.running), 32'd0);

    // Prime with two samples
    push(16'h1234);
    push(16'h5678);
    step();
    chk("prime_u", 32'(ifc.u), 32'h1234);
    chk("prime_level", 32'(ifc.fifo_level), 32'd1);
    chk("prime_running", 32'(ifc.running), 32'd1);
    chk("prime_shift", 32'(ifc.u_rshift), 32'd3);

    // rate_div=2: each sample lasts three consumes
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    ifc.ds_consume = 1'b1;
    repeat (3) step();
    chk("hold3_u", 32'(ifc.u), 32'h5678);
    repeat (9) step();
    chk("drain_u", 32'(ifc.u), 32'h3333);
    chk("drain_level", 32'(ifc.fifo_level), 32'd0);
    chk("drain_underrun", 32'(ifc.underrun), 32'd0);
    repeat (3) step();
    ifc.ds_consume = 1'b0;
    chk("ur_flag", 32'(ifc.underrun), 32'd1);
    chk("ur_running", 32'(ifc.running), 32'd0);
    chk("ur_u", 32'(ifc.u), 32'h3333);

    // Recovery: pop one cycle after the push lands
    push(16'h0AAA);
    chk("rec_wait_u", 32'(ifc.u), 32'h3333);
    step();
    chk("rec_u", 32'(ifc.u), 32'h0AAA);
    chk("rec_running", 32'(ifc.running), 32'd1);
    ifc.underrun_clear = 1'b1;
    step();
    ifc.underrun_clear = 1'b0;
    chk("clr_underrun", 32'(ifc.underrun), 32'd0);

    // Full FIFO, dropped push, pop-only and push+pop
    ifc.rate_div = 8'd50;
    for (int i = 1; i <= 4; i++) push(16'h4000 + 16'(i));
    chk("full_ready", 32'(ifc.in_ready), 32'd0);
    push(16'hDEAD);
    chk("full_level", 32'(ifc.fifo_level), 32'd4);
    ifc.rate_div   = 8'd0;
    ifc.ds_consume = 1'b1;
    step();
    chk("pop_level", 32'(ifc.fifo_level), 32'd3);
    chk("pop_ready", 32'(ifc.in_ready), 32'd1);
    chk("pop_u", 32'(ifc.u), 32'h4001);
    push(16'h4005);
    chk("pp_level", 32'(ifc.fifo_level), 32'd3);
    chk("pp_u", 32'(ifc.u), 32'h4002);
    ifc.ds_consume = 1'b0;

    // Mute and mid-sample volume change
    ifc.rate_div = 8'd3;
    ifc.mute     = 1'b1;
    #1;
    chk("mute_u", 32'(ifc.u), 32'h8000);
    ifc.ds_consume    = 1'b1;
    step();
    ifc.volume_rshift = 4'd9;
    repeat (2) step();
    chk("vol_hold", 32'(ifc.u_rshift), 32'd3);
    repeat (2) step();
    chk("vol_new", 32'(ifc.u_rshift), 32'd9);
    ifc.mute       = 1'b0;
    ifc.ds_consume = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ifc.in_valid       = ($urandom_range(0, 99) < 45);
      ifc.in_data        = 16'($urandom);
      ifc.ds_consume     = ($urandom_range(0, 99) < 50);
      ifc.underrun_clear = ($urandom_range(0, 99) < 5);
      ifc.mute           = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 49) == 0) ifc.rate_div = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ifc.volume_rshift = 4'($urandom);
      step();
    end
    ifc.in_valid       = 1'b0;
    ifc.ds_consume     = 1'b0;
    ifc.underrun_clear = 1'b0;
    ifc.mute           = 1'b0;

    // Asynchronous reset mid-run with samples queued
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifc.rate_div      = 8'd10;
    ifc.volume_rshift = 4'd2;
    for (int i = 0; i < 4; i++) push(16'h7000 + 16'(i));
    chk("pre_rst_level", 32'(ifc.fifo_level), 32'd3);
    chk("pre_rst_running", 32'(ifc.running), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_u", 32'(ifc.u), 32'h8000);
    chk("arst_level", 32'(ifc.fifo_level), 32'd0);
    chk("arst_running", 32'(ifc.running), 32'd0);
    chk("arst_underrun", 32'(ifc.underrun), 32'd0);
    check_model();
    #1 reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
